// File: rtl/next_field_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : next_field_iter_if
//  Description : Bus bundle between the next-field iterator and its
//                environment: go/ready/busy/done handshake, current-field
//                RAM read port, next-field RAM write port, generation count.
//                ROW_AW must equal $clog2(FIELD_H) of the attached iterator.
//  Revision    : 1.0  initial release
// ============================================================================
interface next_field_iter_if #(
    parameter int FIELD_W = 64,
    parameter int ROW_AW  = 6,
    parameter int GEN_W   = 16
);
    logic               i_go;
    logic               o_ready;
    logic               o_busy;
    logic               o_done;
    logic               o_rd_en;
    logic [ROW_AW-1:0]  o_rd_addr;
    logic [FIELD_W-1:0] i_rd_data;
    logic               o_wr_en;
    logic [ROW_AW-1:0]  o_wr_addr;
    logic [FIELD_W-1:0] o_wr_data;
    logic [GEN_W-1:0]   o_gen_cnt;

    // Iterator side
    modport slave (
        input  i_go,
        input  i_rd_data,
        output o_ready,
        output o_busy,
        output o_done,
        output o_rd_en,
        output o_rd_addr,
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data,
        output o_gen_cnt
    );

    // Controller / RAM side
    modport master (
        output i_go,
        output i_rd_data,
        input  o_ready,
        input  o_busy,
        input  o_done,
        input  o_rd_en,
        input  o_rd_addr,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data,
        input  o_gen_cnt
    );
endinterface
`default_nettype wire

// File: rtl/next_field_iter.sv
`default_nettype none
// ============================================================================
//  Module      : next_field_iter
//  Description : Computes one Conway B3/S23 generation from the current-field
//                row RAM into the next-field row RAM, one row word per cycle,
//                using a three-row sliding window over a synchronous RAM.
//                Reads wrap (H-1, 0, 1, .., H-1, 0) so every row sees its
//                upper and lower neighbour.
//                Optional macro NFI_TORUS_EN: toroidal field (columns and rows
//                wrap). Undefined: dead border (outside cells read as 0).
//  Revision    : 1.0  initial release
// ============================================================================
module next_field_iter #(
    parameter int FIELD_W = 64,
    parameter int FIELD_H = 48,
    parameter int GEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    next_field_iter_if.slave  bus
);

    localparam int ROW_AW = $clog2(FIELD_H);
    // Read index runs 0..H+1 in READ and continues to H+3 through DRAIN
    localparam int IDX_W  = $clog2(FIELD_H + 4);

    localparam logic [IDX_W-1:0]  c_first_wr_idx   = IDX_W'(2);
    localparam logic [IDX_W-1:0]  c_last_rd_idx    = IDX_W'(FIELD_H + 1);
    localparam logic [IDX_W-1:0]  c_last_drain_idx = IDX_W'(FIELD_H + 3);
    localparam logic [ROW_AW-1:0] c_last_row       = ROW_AW'(FIELD_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GEN_W-1:0]   gen_cnt_q, gen_cnt_d;

    // Read-data pipeline tag: which read index the RAM is returning now
    logic               rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;

    // Sliding window: mid is the row above the centre, bot is the centre row
    logic [FIELD_W-1:0] mid_q, mid_d;
    logic [FIELD_W-1:0] bot_q, bot_d;

    logic               wr_en_q, wr_en_d;
    logic [ROW_AW-1:0]  wr_addr_q, wr_addr_d;
    logic [FIELD_W-1:0] wr_data_q, wr_data_d;

    logic               rd_en;
    logic [ROW_AW-1:0]  rd_addr;

    logic [FIELD_W-1:0] above_row, centre_row, below_row;
    logic [FIELD_W+1:0] above_ext, centre_ext, below_ext;
    logic [FIELD_W-1:0] next_row;

    // FSM next state, iteration index and generation counter
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gen_cnt_d = gen_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_go) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                end
            end
            ST_READ: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == c_last_rd_idx) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == c_last_drain_idx) begin
                    // Count becomes visible together with o_done
                    state_d   = ST_DONE;
                    gen_cnt_d = gen_cnt_q + GEN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Read address: index 0 fetches the last row, index H+1 fetches row 0
    always_comb begin
        rd_en   = (state_q == ST_READ);
        rd_addr = '0;
        if (rd_en) begin
            if (idx_q == '0) begin
                rd_addr = c_last_row;
            end else if (idx_q == c_last_rd_idx) begin
                rd_addr = '0;
            end else begin
                rd_addr = ROW_AW'(idx_q - IDX_W'(1));
            end
        end
    end

    // Neighbour rows and horizontal edge fill for the rule evaluation
    always_comb begin
        centre_row = bot_q;
`ifdef NFI_TORUS_EN
        above_row  = mid_q;
        below_row  = bus.i_rd_data;
        above_ext  = {above_row[0],  above_row,  above_row[FIELD_W-1]};
        centre_ext = {centre_row[0], centre_row, centre_row[FIELD_W-1]};
        below_ext  = {below_row[0],  below_row,  below_row[FIELD_W-1]};
`else
        // The wrapped-around reads must not influence the border rows
        above_row  = (rd_idx_q == c_first_wr_idx) ? '0 : mid_q;
        below_row  = (rd_idx_q == c_last_rd_idx)  ? '0 : bus.i_rd_data;
        above_ext  = {1'b0, above_row,  1'b0};
        centre_ext = {1'b0, centre_row, 1'b0};
        below_ext  = {1'b0, below_row,  1'b0};
`endif
    end

    // Per-column B3/S23 rule; extended bit i+1 is column i
    for (genvar i = 0; i < FIELD_W; i++) begin : g_cell
        logic [3:0] n;
        assign n = {3'b000, above_ext[i]}  + {3'b000, above_ext[i+1]}
                 + {3'b000, above_ext[i+2]}
                 + {3'b000, centre_ext[i]} + {3'b000, centre_ext[i+2]}
                 + {3'b000, below_ext[i]}  + {3'b000, below_ext[i+1]}
                 + {3'b000, below_ext[i+2]};
        assign next_row[i] = (n == 4'd3) | (centre_ext[i+1] & (n == 4'd2));
    end

    // Window shift and registered write port
    always_comb begin
        rd_vld_d  = rd_en;
        rd_idx_d  = rd_en ? idx_q : '0;
        mid_d     = mid_q;
        bot_d     = bot_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if (rd_vld_q) begin
            mid_d = bot_q;
            bot_d = bus.i_rd_data;
            if (rd_idx_q >= c_first_wr_idx) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ROW_AW'(rd_idx_q - c_first_wr_idx);
                wr_data_d = next_row;
            end
        end
    end

    // State and datapath registers; reset aborts any iteration in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            gen_cnt_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gen_cnt_q <= gen_cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_idx_q  <= rd_idx_d;
            mid_q     <= mid_d;
            bot_q     <= bot_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.o_ready   = (state_q == ST_IDLE);
    assign bus.o_busy    = (state_q != ST_IDLE);
    assign bus.o_done    = (state_q == ST_DONE);
    assign bus.o_rd_en   = rd_en;
    assign bus.o_rd_addr = rd_addr;
    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign bus.o_gen_cnt = gen_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_next_field_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_next_field_iter
//  Description : Self-checking bench for next_field_iter (8x4 field, 2-bit
//                generation counter) against a cell-by-cell Life model.
//                Honours NFI_TORUS_EN the same way as the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_next_field_iter;

    localparam int W       = 8;
    localparam int H       = 4;
    localparam int AW      = 2;
    localparam int GW      = 2;
    localparam int RUN_LEN = H + 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    next_field_iter_if #(.FIELD_W(W), .ROW_AW(AW), .GEN_W(GW)) bus ();

    next_field_iter #(.FIELD_W(W), .FIELD_H(H), .GEN_W(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_gen  = 0;

    logic [W-1:0] cur_mem [0:H-1];
    logic [W-1:0] exp_mem [0:H-1];

    // Synchronous current-field RAM, one cycle read latency
    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_rd_data <= cur_mem[bus.o_rd_addr];
    end

    // Per-cycle capture of one iteration, indexed by cycle after go
    logic          cap_rd_en   [0:15];
    logic [AW-1:0] cap_rd_addr [0:15];
    logic          cap_wr_en   [0:15];
    logic [AW-1:0] cap_wr_addr [0:15];
    logic [W-1:0]  cap_wr_data [0:15];
    logic          cap_done    [0:15];
    logic          cap_busy    [0:15];
    logic          cap_ready   [0:15];
    logic [GW-1:0] cap_gen     [0:15];

    // Next generation straight from the Life rules on a 2D grid
    function automatic void compute_next();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        logic [W-1:0] row;
                        rr = r + dr;
                        cc = c + dc;
                        if (dr != 0 || dc != 0) begin
`ifdef NFI_TORUS_EN
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                            row = cur_mem[rr];
                            n += int'(row[cc]);
`else
                            if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                                row = cur_mem[rr];
                                n += int'(row[cc]);
                            end
`endif
                        end
                    end
                end
                exp_mem[r][c] = (n == 3) || (cur_mem[r][c] && n == 2);
            end
        end
    endfunction

    function automatic void swap_banks();
        for (int r = 0; r < H; r++) cur_mem[r] = exp_mem[r];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_gen = 0;
    endtask

    // Caller is at a negedge; that cycle is cycle 0. Ends at the negedge
    // of cycle RUN_LEN, the DUT back in IDLE.
    task automatic run_iter(input logic [31:0] go_mask);
        bus.i_go = 1'b1;
        for (int c = 1; c <= RUN_LEN; c++) begin
            @(negedge clk);
            cap_rd_en[c]   = bus.o_rd_en;
            cap_rd_addr[c] = bus.o_rd_addr;
            cap_wr_en[c]   = bus.o_wr_en;
            cap_wr_addr[c] = bus.o_wr_addr;
            cap_wr_data[c] = bus.o_wr_data;
            cap_done[c]    = bus.o_done;
            cap_busy[c]    = bus.o_busy;
            cap_ready[c]   = bus.o_ready;
            cap_gen[c]     = bus.o_gen_cnt;
            bus.i_go       = go_mask[c];
        end
        bus.i_go = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.o_ready, bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en} !== 5'b10000 ||
            bus.o_gen_cnt !== '0 || bus.o_wr_addr !== '0 || bus.o_wr_data !== '0 ||
            bus.o_rd_addr !== '0) begin
            $display("FAIL reset_state: rdy/busy/done/rd/wr=%b gen=%0d wa=%0d wd=%h ra=%0d required 10000 0 0 00 0",
                     {bus.o_ready, bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en},
                     bus.o_gen_cnt, bus.o_wr_addr, bus.o_wr_data, bus.o_rd_addr);
        end else n_pass++;
        // go and rst together: reset wins
        rst = 1'b1;
        bus.i_go = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_go = 1'b0;
        n_checks++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            $display("FAIL go_with_rst: ready=%b busy=%b required 1 0", bus.o_ready, bus.o_busy);
        end else n_pass++;
    endtask

    task automatic test_blinker();
        logic [W-1:0] spec_rows [0:H-1];
        spec_rows = '{8'h04, 8'h04, 8'h04, 8'h00};
        do_reset();
        cur_mem = '{8'h00, 8'h0E, 8'h00, 8'h00};
        compute_next();
        run_iter(32'h0);
        exp_gen++;
        for (int c = 1; c <= RUN_LEN; c++) begin
            logic          e_rd, e_wr, e_busy;
            logic [AW-1:0] e_ra;
            e_rd   = (c <= H + 2);
            e_ra   = AW'((c - 2 + H) % H);
            e_wr   = (c >= 5 && c <= H + 4);
            e_busy = (c <= H + 5);
            n_checks++;
            if (cap_rd_en[c] !== e_rd || (e_rd && cap_rd_addr[c] !== e_ra)) begin
                $display("FAIL blinker_read c%0d: en=%b addr=%0d required en=%b addr=%0d",
                         c, cap_rd_en[c], cap_rd_addr[c], e_rd, e_ra);
            end else n_pass++;
            n_checks++;
            if (cap_wr_en[c] !== e_wr ||
                (e_wr && (cap_wr_addr[c] !== AW'(c - 5) || cap_wr_data[c] !== spec_rows[c-5] ||
                          cap_wr_data[c] !== exp_mem[c-5]))) begin
                $display("FAIL blinker_write c%0d: en=%b addr=%0d data=%h required en=%b addr=%0d data=%h",
                         c, cap_wr_en[c], cap_wr_addr[c], cap_wr_data[c], e_wr, c - 5,
                         e_wr ? spec_rows[c-5] : 8'h00);
            end else n_pass++;
            n_checks++;
            if (cap_done[c] !== (c == H + 5) || cap_busy[c] !== e_busy || cap_ready[c] !== !e_busy) begin
                $display("FAIL blinker_status c%0d: done=%b busy=%b ready=%b required %b %b %b",
                         c, cap_done[c], cap_busy[c], cap_ready[c], c == H + 5, e_busy, !e_busy);
            end else n_pass++;
        end
        n_checks++;
        if (cap_gen[H+5] !== 2'(exp_gen)) begin
            $display("FAIL blinker_gen: got %0d required %0d", cap_gen[H+5], exp_gen);
        end else n_pass++;
    endtask

    task automatic test_still_life();
        do_reset();
        cur_mem = '{8'h00, 8'h18, 8'h18, 8'h00};
        for (int g = 0; g < 3; g++) begin
            compute_next();
            run_iter(32'h0);
            exp_gen++;
            for (int r = 0; r < H; r++) begin
                n_checks++;
                if (cap_wr_en[5+r] !== 1'b1 || cap_wr_data[5+r] !== cur_mem[r] ||
                    cap_wr_data[5+r] !== exp_mem[r]) begin
                    $display("FAIL still_life g%0d row%0d: en=%b data=%h required 1 %h",
                             g, r, cap_wr_en[5+r], cap_wr_data[5+r], cur_mem[r]);
                end else n_pass++;
            end
            swap_banks();
        end
        n_checks++;
        if (cap_gen[H+5] !== 2'd3 || cap_done[H+5] !== 1'b1) begin
            $display("FAIL still_life_gen: gen=%0d done=%b required 3 1", cap_gen[H+5], cap_done[H+5]);
        end else n_pass++;
    endtask

    task automatic test_edge_wrap();
        logic [W-1:0] spec_rows [0:H-1];
`ifdef NFI_TORUS_EN
        spec_rows = '{8'h01, 8'h01, 8'h00, 8'h01};
`else
        spec_rows = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
        do_reset();
        cur_mem = '{8'h83, 8'h00, 8'h00, 8'h00};
        compute_next();
        run_iter(32'h0);
        for (int r = 0; r < H; r++) begin
            n_checks++;
            if (cap_wr_en[5+r] !== 1'b1 || cap_wr_addr[5+r] !== AW'(r) ||
                cap_wr_data[5+r] !== spec_rows[r] || cap_wr_data[5+r] !== exp_mem[r]) begin
                $display("FAIL edge_wrap row%0d: en=%b addr=%0d data=%h required 1 %0d %h",
                         r, cap_wr_en[5+r], cap_wr_addr[5+r], cap_wr_data[5+r], r, spec_rows[r]);
            end else n_pass++;
        end
    endtask

    task automatic test_go_while_busy();
        int n_wr, n_done;
        do_reset();
        cur_mem = '{8'h3C, 8'h42, 8'h18, 8'h81};
        compute_next();
        run_iter((32'h1 << 3) | (32'h1 << 9));
        exp_gen++;
        n_wr = 0;
        n_done = 0;
        for (int c = 1; c <= RUN_LEN; c++) begin
            n_wr   += int'(cap_wr_en[c]);
            n_done += int'(cap_done[c]);
        end
        n_checks++;
        if (n_wr != H || n_done != 1 || cap_ready[RUN_LEN] !== 1'b1) begin
            $display("FAIL go_while_busy: writes=%0d dones=%0d ready@10=%b required %0d 1 1",
                     n_wr, n_done, cap_ready[RUN_LEN], H);
        end else n_pass++;
        swap_banks();
        compute_next();
        run_iter(32'h0);
        exp_gen++;
        n_checks++;
        if (cap_done[H+5] !== 1'b1 || cap_gen[H+5] !== 2'(exp_gen) || cap_wr_data[5] !== exp_mem[0]) begin
            $display("FAIL go_after_busy: done=%b gen=%0d row0=%h required 1 %0d %h",
                     cap_done[H+5], cap_gen[H+5], cap_wr_data[5], exp_gen, exp_mem[0]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int bad;
        do_reset();
        cur_mem = '{8'h0E, 8'h00, 8'h70, 8'h00};
        run_iter(32'h0);
        // gen count is now nonzero, so clearing it is observable
        bus.i_go = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.i_go = 1'b0;
            if (c == 6) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.o_wr_en, bus.o_rd_en, bus.o_done, bus.o_busy, bus.o_ready} !== 5'b00001 ||
            bus.o_gen_cnt !== '0) begin
            $display("FAIL reset_mid_run: wr/rd/done/busy/ready=%b gen=%0d required 00001 0",
                     {bus.o_wr_en, bus.o_rd_en, bus.o_done, bus.o_busy, bus.o_ready}, bus.o_gen_cnt);
        end else n_pass++;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.o_wr_en || bus.o_rd_en || bus.o_done) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL reset_quiet: active cycles=%0d required 0", bad);
        end else n_pass++;
        exp_gen = 0;
        compute_next();
        run_iter(32'h0);
        exp_gen++;
        n_checks++;
        if (cap_done[H+5] !== 1'b1 || cap_gen[H+5] !== 2'(exp_gen) || cap_wr_data[H+4] !== exp_mem[H-1]) begin
            $display("FAIL restart_after_reset: done=%b gen=%0d row3=%h required 1 %0d %h",
                     cap_done[H+5], cap_gen[H+5], cap_wr_data[H+4], exp_gen, exp_mem[H-1]);
        end else n_pass++;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int r = 0; r < H; r++) cur_mem[r] = W'($urandom_range(0, 255));
        for (int g = 1; g <= 4; g++) begin
            compute_next();
            run_iter(32'h0);
            exp_gen++;
            n_checks++;
            if (cap_gen[H+5] !== 2'(exp_gen % 4) || cap_done[H+5] !== 1'b1) begin
                $display("FAIL counter_wrap it%0d: gen=%0d done=%b required %0d 1",
                         g, cap_gen[H+5], cap_done[H+5], exp_gen % 4);
            end else n_pass++;
            swap_banks();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < H; r++) cur_mem[r] = W'($urandom_range(0, 255));
            for (int g = 0; g < 2; g++) begin
                compute_next();
                run_iter(32'h0);
                exp_gen++;
                for (int c = 1; c <= RUN_LEN; c++) begin
                    logic e_wr;
                    e_wr = (c >= 5 && c <= H + 4);
                    if (e_wr || cap_wr_en[c]) begin
                        n_checks++;
                        if (cap_wr_en[c] !== e_wr ||
                            (e_wr && (cap_wr_addr[c] !== AW'(c - 5) || cap_wr_data[c] !== exp_mem[c-5]))) begin
                            $display("FAIL random t%0d g%0d c%0d: en=%b addr=%0d data=%h required en=%b addr=%0d data=%h",
                                     t, g, c, cap_wr_en[c], cap_wr_addr[c], cap_wr_data[c], e_wr, c - 5,
                                     e_wr ? exp_mem[c-5] : 8'h00);
                        end else n_pass++;
                    end
                end
                n_checks++;
                if (cap_done[H+5] !== 1'b1 || cap_gen[H+5] !== 2'(exp_gen % 4)) begin
                    $display("FAIL random_done t%0d g%0d: done=%b gen=%0d required 1 %0d",
                             t, g, cap_done[H+5], cap_gen[H+5], exp_gen % 4);
                end else n_pass++;
                swap_banks();
            end
        end
    endtask

    initial begin
        bus.i_go = 1'b0;
        bus.i_rd_data = '0;
        test_reset();
        test_blinker();
        test_still_life();
        test_edge_wrap();
        test_go_while_busy();
        test_reset_mid_run();
        test_counter_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
